// File: rtl/counter_arbiter.sv
// counter_arbiter
//
// Round-robin arbiter in front of a shared WIDTH-bit counter. Each client
// presents an operation (read / inc / dec / load) on a valid/ready handshake.
// One client is granted per cycle. The granted operation is applied to the
// counter on the same clock edge, and the result is reported on the following
// cycle.
//
// Ports:
//   clock      - single clock, all state updates on posedge
//   reset_     - synchronous, active-low reset
//   req_valid  - per-client request valid            [REQUESTERS]
//   req_op     - per-client op, client i at [2i+1:2i]
//                00 read, 01 inc, 10 dec, 11 load    [2*REQUESTERS]
//   req_data   - per-client load value, client i at [WIDTH*i +: WIDTH]
//   req_ready  - one-hot combinational grant, all-zero in reset / when idle
//   out        - registered counter value
//   done       - one-cycle pulse: an op was applied on the previous edge
//   done_id    - index of the client served by that op (held while done=0)
//   wrap       - one-cycle pulse: previous op was inc from all-ones or
//                dec from zero

module counter_arbiter #(
    parameter int WIDTH      = 16,
    parameter int REQUESTERS = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                        clock,
    input  logic                        reset_,
    input  logic [REQUESTERS-1:0]       req_valid,
    input  logic [2*REQUESTERS-1:0]     req_op,
    input  logic [WIDTH*REQUESTERS-1:0] req_data,
    output logic [REQUESTERS-1:0]       req_ready,
    output logic [WIDTH-1:0]            out,
    output logic                        done,
    output logic [ID_WIDTH-1:0]         done_id,
    output logic                        wrap
);

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(REQUESTERS - 1);

    // True when the operation crosses the modular boundary of the counter.
    function automatic logic wrap_detect(input logic [1:0]       op,
                                         input logic [WIDTH-1:0] cnt);
        logic hit;
        case (op)
            OP_INC:  hit = &cnt;
            OP_DEC:  hit = ~|cnt;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Counter value after applying one operation.
    function automatic logic [WIDTH-1:0] apply_op(input logic [1:0]       op,
                                                  input logic [WIDTH-1:0] cnt,
                                                  input logic [WIDTH-1:0] data);
        logic [WIDTH-1:0] res;
        case (op)
            OP_READ: res = cnt;
            OP_INC:  res = cnt + WIDTH'(1);
            OP_DEC:  res = cnt - WIDTH'(1);
            OP_LOAD: res = data;
            default: res = cnt;
        endcase
        return res;
    endfunction

    // Pointer advance: one past the winner, wrapping at REQUESTERS.
    function automatic logic [ID_WIDTH-1:0] ptr_after(input logic [ID_WIDTH-1:0] id);
        logic [ID_WIDTH-1:0] nxt;
        if (id == LAST_ID) begin
            nxt = '0;
        end else begin
            nxt = id + ID_WIDTH'(1);
        end
        return nxt;
    endfunction

    logic [WIDTH-1:0]      count_r;
    logic [ID_WIDTH-1:0]   next_r;
    logic                  done_r;
    logic [ID_WIDTH-1:0]   done_id_r;
    logic                  wrap_r;

    logic                  grant_found_s;
    logic [ID_WIDTH-1:0]   grant_id_s;
    logic [REQUESTERS-1:0] grant_onehot_s;
    logic                  xfer_s;
    logic [1:0]            sel_op_s;
    logic [WIDTH-1:0]      sel_data_s;
    logic [WIDTH-1:0]      count_next_s;
    logic                  wrap_next_s;

    // Winner search. The first pass covers clients at or above the pointer,
    // the second pass covers the ones below it. Together they give an
    // ascending modulo scan that starts at next_r.
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (!grant_found_s && req_valid[i] && (ID_WIDTH'(i) >= next_r)) begin
                grant_found_s = 1'b1;
                grant_id_s    = ID_WIDTH'(i);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        for (int i = 0; i < REQUESTERS; i++) begin
            if (!grant_found_s && req_valid[i] && (ID_WIDTH'(i) < next_r)) begin
                grant_found_s = 1'b1;
                grant_id_s    = ID_WIDTH'(i);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // One-hot grant, suppressed while reset is held so no transfer can occur.
    always_comb begin
        grant_onehot_s = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (reset_ && grant_found_s && (grant_id_s == ID_WIDTH'(i))) begin
                grant_onehot_s[i] = 1'b1;
            end else begin
                grant_onehot_s[i] = 1'b0;
            end
        end
    end

    assign req_ready = grant_onehot_s;
    assign xfer_s    = |grant_onehot_s;

    // Route the winner's op and load data to the counter datapath.
    always_comb begin
        sel_op_s   = OP_READ;
        sel_data_s = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (grant_id_s == ID_WIDTH'(i)) begin
                sel_op_s   = req_op[2*i +: 2];
                sel_data_s = req_data[WIDTH*i +: WIDTH];
            end else begin
                sel_op_s   = sel_op_s;
            end
        end
    end

    // Next counter value and wrap flag for the selected operation.
    always_comb begin
        count_next_s = apply_op(sel_op_s, count_r, sel_data_s);
        wrap_next_s  = wrap_detect(sel_op_s, count_r);
    end

    // Counter, pointer and result registers. The reset is synchronous.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            count_r   <= '0;
            next_r    <= '0;
            done_r    <= 1'b0;
            done_id_r <= '0;
            wrap_r    <= 1'b0;
        end else if (xfer_s) begin
            count_r   <= count_next_s;
            next_r    <= ptr_after(grant_id_s);
            done_r    <= 1'b1;
            done_id_r <= grant_id_s;
            wrap_r    <= wrap_next_s;
        end else begin
            done_r    <= 1'b0;
            wrap_r    <= 1'b0;
        end
    end

    assign out     = count_r;
    assign done    = done_r;
    assign done_id = done_id_r;
    assign wrap    = wrap_r;

endmodule
